b2r_tile_scheduler: RTL and testbench

- Controls the row buffer between the block-to-row (b2r) converter and the softmax tile stream.
- Write side: accepts full rows (WIDTH*COL bits) from b2r into a circular buffer of BUF_ROWS rows.
- Read side: issues TILE_SIZE-wide reads to the buffer and presents them downstream with valid/ready backpressure.
- Stalls b2r when the buffer is full. Contains only control logic; the dual-port buffer RAM (read latency 1, output held while read enable is low) is external.

---
 rtl/b2r_sched_pkg.sv | 26 ++
 rtl/tile_read_ctrl.sv | 108 ++++++++++
 rtl/b2r_tile_scheduler.sv | 144 ++++++++++++++
 tb/tb_b2r_tile_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/b2r_sched_pkg.sv
// Shared definitions for the b2r row-buffer tile scheduler.
// Holds the scheduler state enum, the tiles-per-row helper and the
// parameter-legality check that the top evaluates at elaboration.
package b2r_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sched_state_e;

  function automatic int unsigned tiles_per_row(input int unsigned col,
                                                input int unsigned tile_size);
    return col / tile_size;
  endfunction

  // Rows must split into whole tiles; slot pointers rely on natural wrap.
  function automatic bit sched_params_ok(input int unsigned col,
                                         input int unsigned tile_size,
                                         input int unsigned buf_rows);
    return (tile_size != 0) && ((col % tile_size) == 0) && (buf_rows >= 2) &&
           ((buf_rows & (buf_rows - 1)) == 0);
  endfunction

endpackage

// File: rtl/tile_read_ctrl.sv
// Read side of the b2r row buffer: walks tile_idx / rd_slot / rd_row_cnt,
// issues port-B reads and keeps the valid/last flags aligned with the RAM
// output register (read latency 1, held while buf_re is low).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        new matrix accepted, rewind read pointers
//   active       scheduler is in RUN or DRAIN
//   rows_avail   at least one buffered row still has tiles to issue
//   tile_ready   downstream accepts the presented tile
//   buf_re       port-B read enable
//   buf_raddr    rd_slot*TILES_PER_ROW + tile_idx
//   tile_valid, tile_last, mat_last  registered, aligned with doutb
//   row_issued   buf_re of the last tile of a row (frees a slot)
module tile_read_ctrl
  import b2r_sched_pkg::*;
#(
  parameter int unsigned ROW       = 256,
  parameter int unsigned COL       = 64,
  parameter int unsigned TILE_SIZE = 8,
  parameter int unsigned BUF_ROWS  = 4,
  localparam int unsigned TILES_PER_ROW = tiles_per_row(COL, TILE_SIZE),
  localparam int unsigned RA_W = $clog2(BUF_ROWS * TILES_PER_ROW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            active,
  input  logic            rows_avail,
  input  logic            tile_ready,
  output logic            buf_re,
  output logic [RA_W-1:0] buf_raddr,
  output logic            tile_valid,
  output logic            tile_last,
  output logic            mat_last,
  output logic            row_issued
);

  localparam int unsigned WA_W  = $clog2(BUF_ROWS);
  localparam int unsigned TI_W  = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;
  localparam int unsigned CNT_W = $clog2(ROW + 1);
  localparam logic [TI_W-1:0]  LastTile = TI_W'(TILES_PER_ROW - 1);
  localparam logic [CNT_W-1:0] LastRow  = CNT_W'(ROW - 1);

  logic [TI_W-1:0]  tile_idx_q, tile_idx_d;
  logic [WA_W-1:0]  rd_slot_q, rd_slot_d;
  logic [CNT_W-1:0] rd_row_cnt_q, rd_row_cnt_d;
  logic             tile_valid_q, tile_valid_d;
  logic             tile_last_q, tile_last_d;
  logic             mat_last_q, mat_last_d;
  logic             at_last_tile;

  assign at_last_tile = (tile_idx_q == LastTile);
  // A held tile blocks new reads so doutb and the flags stay put.
  assign buf_re       = active && rows_avail && (!tile_valid_q || tile_ready);
  assign row_issued   = buf_re && at_last_tile;
  assign buf_raddr    = RA_W'(rd_slot_q) * RA_W'(TILES_PER_ROW) + RA_W'(tile_idx_q);
  assign tile_valid   = tile_valid_q;
  assign tile_last    = tile_last_q;
  assign mat_last     = mat_last_q;

  always_comb begin
    tile_idx_d   = tile_idx_q;
    rd_slot_d    = rd_slot_q;
    rd_row_cnt_d = rd_row_cnt_q;
    tile_valid_d = tile_valid_q;
    tile_last_d  = tile_last_q;
    mat_last_d   = mat_last_q;
    if (clear) begin
      tile_idx_d   = '0;
      rd_slot_d    = '0;
      rd_row_cnt_d = '0;
    end else if (buf_re) begin
      tile_valid_d = 1'b1;
      tile_last_d  = at_last_tile;
      mat_last_d   = at_last_tile && (rd_row_cnt_q == LastRow);
      if (at_last_tile) begin
        tile_idx_d   = '0;
        rd_slot_d    = rd_slot_q + 1'b1;
        rd_row_cnt_d = rd_row_cnt_q + 1'b1;
      end else begin
        tile_idx_d = tile_idx_q + 1'b1;
      end
    end else if (tile_valid_q && tile_ready) begin
      tile_valid_d = 1'b0;
      tile_last_d  = 1'b0;
      mat_last_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_idx_q   <= '0;
      rd_slot_q    <= '0;
      rd_row_cnt_q <= '0;
      tile_valid_q <= 1'b0;
      tile_last_q  <= 1'b0;
      mat_last_q   <= 1'b0;
    end else begin
      tile_idx_q   <= tile_idx_d;
      rd_slot_q    <= rd_slot_d;
      rd_row_cnt_q <= rd_row_cnt_d;
      tile_valid_q <= tile_valid_d;
      tile_last_q  <= tile_last_d;
      mat_last_q   <= mat_last_d;
    end
  end

endmodule

// File: rtl/b2r_tile_scheduler.sv
// Control for the row buffer between the b2r converter and the softmax tile
// stream. Owns the matrix FSM, the write pointer and slot occupancy; the
// read walk lives in tile_read_ctrl. The dual-port buffer RAM is external.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin one matrix of ROW rows (IDLE only)
//   row_in_valid/ready    row handshake with b2r
//   buf_we, buf_waddr     port-A write of a whole row slot
//   buf_re, buf_raddr     port-B tile read
//   tile_valid/ready      tile handshake with softmax
//   tile_last, mat_last   qualify tile_valid
//   busy                  not IDLE
//   mat_done              one-cycle pulse after the final tile handshake
module b2r_tile_scheduler
  import b2r_sched_pkg::*;
#(
  parameter int unsigned ROW       = 256,
  parameter int unsigned COL       = 64,
  parameter int unsigned TILE_SIZE = 8,
  parameter int unsigned BUF_ROWS  = 4,
  localparam int unsigned TILES_PER_ROW = tiles_per_row(COL, TILE_SIZE),
  localparam int unsigned WA_W = $clog2(BUF_ROWS),
  localparam int unsigned RA_W = $clog2(BUF_ROWS * TILES_PER_ROW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            row_in_valid,
  output logic            row_in_ready,
  output logic            buf_we,
  output logic [WA_W-1:0] buf_waddr,
  output logic            buf_re,
  output logic [RA_W-1:0] buf_raddr,
  output logic            tile_valid,
  input  logic            tile_ready,
  output logic            tile_last,
  output logic            mat_last,
  output logic            busy,
  output logic            mat_done
);

  if (!sched_params_ok(COL, TILE_SIZE, BUF_ROWS)) begin : g_bad_params
    $error("b2r_tile_scheduler: COL must be a multiple of TILE_SIZE, BUF_ROWS a power of 2 >= 2");
  end

  localparam int unsigned CNT_W = $clog2(ROW + 1);
  localparam int unsigned OCC_W = $clog2(BUF_ROWS + 1);
  localparam logic [CNT_W-1:0] LastRow = CNT_W'(ROW - 1);
  localparam logic [OCC_W-1:0] OccFull = OCC_W'(BUF_ROWS);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [WA_W-1:0]  wr_slot_q, wr_slot_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_run, rd_active, start_acc, row_issued;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (buf_we && (wr_cnt_q == LastRow)) state_d = StDrain;
      StDrain: if (tile_valid && tile_ready && mat_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state_q != StIdle);
    mat_done  = (state_q == StDone);
    in_run    = (state_q == StRun);
    rd_active = (state_q == StRun) || (state_q == StDrain);
    start_acc = (state_q == StIdle) && start;
  end

  // A slot freed this cycle only becomes writable next cycle.
  assign row_in_ready = in_run && (occ_q < OccFull);
  assign buf_we       = row_in_valid && row_in_ready;
  assign buf_waddr    = wr_slot_q;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_slot_d = wr_slot_q;
    occ_d     = occ_q;
    if (start_acc) begin
      wr_cnt_d  = '0;
      wr_slot_d = '0;
    end else if (buf_we) begin
      wr_cnt_d  = wr_cnt_q + 1'b1;
      wr_slot_d = wr_slot_q + 1'b1;
    end
    case ({buf_we, row_issued})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_slot_q <= '0;
      occ_q     <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_slot_q <= wr_slot_d;
      occ_q     <= occ_d;
    end
  end

  tile_read_ctrl #(
    .ROW       (ROW),
    .COL       (COL),
    .TILE_SIZE (TILE_SIZE),
    .BUF_ROWS  (BUF_ROWS)
  ) u_tile_read_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_acc),
    .active     (rd_active),
    .rows_avail (occ_q != '0),
    .tile_ready (tile_ready),
    .buf_re     (buf_re),
    .buf_raddr  (buf_raddr),
    .tile_valid (tile_valid),
    .tile_last  (tile_last),
    .mat_last   (mat_last),
    .row_issued (row_issued)
  );

  a_occ_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_we && !row_issued && (occ_q == OccFull)));
  a_occ_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(row_issued && !buf_we && (occ_q == '0)));

endmodule

// File: tb/tb_b2r_tile_scheduler.sv
// Bench for b2r_tile_scheduler with ROW=4, COL=16, TILE_SIZE=8, BUF_ROWS=2.
module tb_b2r_tile_scheduler;

  localparam int unsigned ROW       = 4;
  localparam int unsigned COL       = 16;
  localparam int unsigned TILE_SIZE = 8;
  localparam int unsigned BUF_ROWS  = 2;
  localparam int unsigned TPR       = COL / TILE_SIZE;
  localparam int unsigned TOTAL     = ROW * TPR;
  localparam int unsigned WA_W      = $clog2(BUF_ROWS);
  localparam int unsigned RA_W      = $clog2(BUF_ROWS * TPR);

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            row_in_valid;
  logic            row_in_ready;
  logic            buf_we;
  logic [WA_W-1:0] buf_waddr;
  logic            buf_re;
  logic [RA_W-1:0] buf_raddr;
  logic            tile_valid;
  logic            tile_ready;
  logic            tile_last;
  logic            mat_last;
  logic            busy;
  logic            mat_done;

  b2r_tile_scheduler #(
    .ROW       (ROW),
    .COL       (COL),
    .TILE_SIZE (TILE_SIZE),
    .BUF_ROWS  (BUF_ROWS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .row_in_valid (row_in_valid),
    .row_in_ready (row_in_ready),
    .buf_we       (buf_we),
    .buf_waddr    (buf_waddr),
    .buf_re       (buf_re),
    .buf_raddr    (buf_raddr),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .tile_last    (tile_last),
    .mat_last     (mat_last),
    .busy         (busy),
    .mat_done     (mat_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: matrix progress as plain counts.
  bit active;     // matrix started, final tile not yet accepted
  bit done_pend;  // the cycle after the final handshake
  int n_wr, n_iss, n_hs, mats_done;
  // Environment: external RAM and its output register.
  logic [7:0] ram [BUF_ROWS*TPR];
  logic [7:0] dout;
  int dut_we, dut_re, dut_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, update model for the rising edge.
  task automatic cycle();
    int         occ_m;
    bit         was_idle, tv_exp, rdy_exp, re_exp, hs, fin;
    logic [7:0] rd_word;
    @(negedge clk);
    was_idle = !active && !done_pend;
    occ_m    = n_wr - n_iss / TPR;
    tv_exp   = n_iss > n_hs;
    rdy_exp  = active && (n_wr < ROW) && (occ_m < BUF_ROWS);
    re_exp   = active && (occ_m > 0) && (!tv_exp || tile_ready);
    hs       = tv_exp && tile_ready;
    check("row_in_ready", row_in_ready, rdy_exp);
    check("buf_we", buf_we, row_in_valid && rdy_exp);
    check("tile_valid", tile_valid, tv_exp);
    check("buf_re", buf_re, re_exp);
    check("busy", busy, active || done_pend);
    check("mat_done", mat_done, done_pend);
    if (hs) begin
      check("tile_data", dout, 8'((n_hs / TPR) * 16 + n_hs % TPR));
      check("tile_last", tile_last, (n_hs % TPR) == TPR - 1);
      check("mat_last", mat_last, n_hs == TOTAL - 1);
    end
    if (buf_we) check("buf_waddr", buf_waddr, n_wr % BUF_ROWS);
    if (buf_re) check("buf_raddr", buf_raddr, ((n_iss / TPR) % BUF_ROWS) * TPR + n_iss % TPR);
    // RAM reacts to what the DUT actually drives (read-before-write).
    rd_word = dout;
    if (buf_re) rd_word = ram[buf_raddr];
    if (buf_we) for (int t = 0; t < TPR; t++) ram[buf_waddr * TPR + t] = 8'(dut_we * 16 + t);
    dout = rd_word;
    if (buf_we) dut_we++;
    if (buf_re) dut_re++;
    if (tile_valid && tile_ready) dut_hs++;
    if (rdy_exp && row_in_valid) n_wr++;
    if (re_exp) n_iss++;
    fin = 1'b0;
    if (hs) begin
      fin = (n_hs == TOTAL - 1);
      n_hs++;
    end
    if (done_pend) begin
      done_pend = 1'b0;
      mats_done++;
    end
    if (fin) begin
      active    = 1'b0;
      done_pend = 1'b1;
    end
    if (start && was_idle) begin
      active = 1'b1;
      n_wr   = 0;
      n_iss  = 0;
      n_hs   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    active    = 1'b0;
    done_pend = 1'b0;
    n_wr      = 0;
    n_iss     = 0;
    n_hs      = 0;
    check("rst_row_in_ready", row_in_ready, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_waddr", buf_waddr, 0);
    check("rst_buf_re", buf_re, 0);
    check("rst_buf_raddr", buf_raddr, 0);
    check("rst_tile_valid", tile_valid, 0);
    check("rst_tile_last", tile_last, 0);
    check("rst_mat_last", mat_last, 0);
    check("rst_busy", busy, 0);
    check("rst_mat_done", mat_done, 0);
    rst_n = 1'b1;
  endtask

  // ready_mode: 0 held high, 1 pattern 1,0,0, 2 random. valid_mode: 0 held, 2 random.
  task automatic run_matrix(input int ready_mode, input int valid_mode, input bit poke_start,
                            input int pre_stall);
    int done_before;
    dut_we = 0;
    dut_re = 0;
    dut_hs = 0;
    start  = 1'b1;
    cycle();
    start  = 1'b0;
    done_before = mats_done;
    for (int c = 0; c < pre_stall; c++) begin
      tile_ready   = 1'b0;
      row_in_valid = 1'b1;
      cycle();
    end
    if (pre_stall > 0) begin
      check("full_ready_low", row_in_ready, 0);
      check("full_two_writes", dut_we, BUF_ROWS);
      check("full_tile_held", tile_valid, 1);
      check("full_no_read", buf_re, 0);
    end
    for (int c = 0; c < 400 && mats_done == done_before; c++) begin
      row_in_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (ready_mode)
        0:       tile_ready = 1'b1;
        1:       tile_ready = (c % 3 == 0);
        default: tile_ready = 1'($urandom_range(0, 1));
      endcase
      start = poke_start ? ($urandom_range(0, 5) == 0) : 1'b0;
      cycle();
    end
    start = 1'b0;
    check("matrix_completes", mats_done - done_before, 1);
    check("rows_written", dut_we, ROW);
    check("tiles_accepted", dut_hs, TOTAL);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    mats_done    = 0;
    dout         = '0;
    rst_n        = 1'b0;
    start        = 1'b0;
    row_in_valid = 1'b0;
    tile_ready   = 1'b0;
    do_reset();

    // Rows offered while idle must be refused.
    dut_we       = 0;
    row_in_valid = 1'b1;
    tile_ready   = 1'b1;
    repeat (3) cycle();
    check("idle_no_we", dut_we, 0);
    check("idle_not_ready", row_in_ready, 0);

    run_matrix(0, 0, 1'b0, 0);      // streaming
    run_matrix(0, 0, 1'b0, 6);      // full buffer, then drain
    run_matrix(1, 0, 1'b0, 0);      // backpressure 1,0,0
    repeat (4) run_matrix(2, 2, 1'b1, 0);  // random, stray start pulses

    // Abort mid-matrix, then a fresh matrix must behave as if new.
    dut_we       = 0;
    dut_re       = 0;
    dut_hs       = 0;
    row_in_valid = 1'b1;
    tile_ready   = 1'b1;
    start        = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 50 && dut_re < 3; c++) cycle();
    check("abort_reached_point", dut_re, 3);
    do_reset();
    cycle();
    check("abort_no_done", mat_done, 0);
    run_matrix(0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
